// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory responder: FSM states, lane-select
// codes and small lane helpers used by the load path and the array writer.
package mem_pkg;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  localparam logic [3:0] SEL_NONE = 4'b0000;
  localparam logic [3:0] SEL_B0   = 4'b0001;
  localparam logic [3:0] SEL_B1   = 4'b0010;
  localparam logic [3:0] SEL_B2   = 4'b0100;
  localparam logic [3:0] SEL_B3   = 4'b1000;
  localparam logic [3:0] SEL_H0   = 4'b0011;
  localparam logic [3:0] SEL_H1   = 4'b1100;
  localparam logic [3:0] SEL_W    = 4'b1111;

  // Expand a 4-bit lane select into a 32-bit byte mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (sel[i]) m[8*i +: 8] = 8'hFF;
    end
    return m;
  endfunction

endpackage

// File: rtl/load_align.sv
// Load alignment: picks the selected byte/halfword/word out of a memory word,
// right-aligns it and sign- or zero-extends it. Illegal selects pass the
// masked word through unextended and raise the illegal flag.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] mem_word,
  input  logic [3:0]  sel,
  input  logic        extend,
  output logic [31:0] result,
  output logic        illegal
);

  // Decode the lane select into an aligned, extended load value.
  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (sel)
      SEL_NONE: result = '0;
      SEL_B0:   result = {{24{extend & mem_word[7]}},  mem_word[7:0]};
      SEL_B1:   result = {{24{extend & mem_word[15]}}, mem_word[15:8]};
      SEL_B2:   result = {{24{extend & mem_word[23]}}, mem_word[23:16]};
      SEL_B3:   result = {{24{extend & mem_word[31]}}, mem_word[31:24]};
      SEL_H0:   result = {{16{extend & mem_word[15]}}, mem_word[15:0]};
      SEL_H1:   result = {{16{extend & mem_word[31]}}, mem_word[31:16]};
      SEL_W:    result = mem_word;
      default: begin
        result  = mem_word & lane_mask(sel);
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory target for the CPU MEM stage. After reset a clear walk zeroes
// the whole array with mem_ready low; afterwards it services byte-lane stores
// and combinational aligned loads, counts stores and latches bad lane selects.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_BITS-3:0] ram_addr,
  input  logic [31:0]          ram_data_in,
  input  logic [3:0]           ram_sel,
  input  logic                 ram_rw,
  input  logic                 ram_extend_type,
  output logic [31:0]          ram_data_out,
  output logic                 mem_ready,
  output logic [31:0]          store_num,
  output logic                 sel_err
);

  localparam int unsigned WADDR = ADDR_BITS - 2;
  localparam int unsigned DEPTH = 1 << WADDR;

  logic [0:0]       state;
  logic [WADDR-1:0] clr_ptr;
  logic [31:0]      mem [DEPTH];
  logic             idle;
  logic [31:0]      rd_word;
  logic [31:0]      aligned;
  logic             sel_illegal;

  assign idle      = (state == ST_IDLE);
  assign mem_ready = idle;
  assign rd_word   = mem[ram_addr];

  load_align u_load_align (
    .mem_word (rd_word),
    .sel      (ram_sel),
    .extend   (ram_extend_type),
    .result   (aligned),
    .illegal  (sel_illegal)
  );

  assign ram_data_out = (idle && !ram_rw) ? aligned : '0;

  // Clear walk: one word per cycle; the last address is all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
    end else if (state == ST_CLEAR) begin
      clr_ptr <= clr_ptr + 1'b1;
      if (clr_ptr == '1) state <= ST_IDLE;
    end
  end

  // Array write port: clear walk has priority, otherwise byte-lane stores.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[clr_ptr] <= '0;
    end else if (ram_rw) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (ram_sel[i]) mem[ram_addr][8*i +: 8] <= ram_data_in[8*i +: 8];
      end
    end
  end

  // Count accepted stores (any non-empty lane set, legal or not).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_num <= '0;
    end else if (idle && ram_rw && (ram_sel != SEL_NONE)) begin
      store_num <= store_num + 1'b1;
    end
  end

  // Sticky flag for any illegal lane select seen on a load or store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err <= 1'b0;
    end else if (idle && sel_illegal) begin
      sel_err <= 1'b1;
    end
  end

endmodule
